// File: rtl/sync_scan_mux.sv
// sync_scan_mux
//   Registered N-way channel multiplexer. A channel can be selected by a
//   one-cycle load strobe, or the channels can be visited round-robin with a
//   fixed dwell time. Every channel change blanks the output for one cycle,
//   then signals the first data from the new channel with a one-cycle pulse.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_data    packed channels, channel k at bits [k*WIDTH +: WIDTH]
//   sel        requested channel, used only while sel_load is high
//   sel_load   one-cycle strobe requesting a switch to sel
//   scan_en    level, 1 = automatic round-robin scan
//   out        registered data of the current channel
//   out_sel    current channel index
//   out_valid  out carries data of the current channel
//   switched   one-cycle pulse when data of a new channel first appears
//   sel_err    one-cycle pulse after a load request with sel >= CHANNELS
module sync_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 16,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  input  logic                      scan_en,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      switched,
  output logic                      sel_err
);

  localparam int CNT_W = $clog2(DWELL);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  // sel is compared one bit wider so CHANNELS itself is representable
  // when CHANNELS is a power of two.
  localparam logic [SEL_W:0]   CH_LIMIT   = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] cur_data;
  logic [SEL_W-1:0] next_sel;
  logic             sel_ok;
  logic             load_req;

  // Data of the currently selected channel. A compare loop keeps indices
  // beyond CHANNELS-1 from ever addressing outside in_data.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (out_sel == SEL_W'(k)) begin
        cur_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_ok   = ({1'b0, sel} < CH_LIMIT);
  assign load_req = sel_load && sel_ok;
  assign next_sel = (out_sel == LAST_SEL) ? '0 : out_sel + SEL_W'(1);

  // Main FSM. out_sel doubles as the pending target: it is updated on
  // entry to SWITCH, so the exit edge samples the new channel directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      switched  <= 1'b0;
      sel_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      switched <= 1'b0;
      sel_err  <= sel_load && !sel_ok;
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          out       <= cur_data;
          out_valid <= 1'b1;
          // A manual load beats a scan advance due on the same edge.
          if (load_req && (sel != out_sel)) begin
            out_sel   <= sel;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= SWITCH;
          end else if (scan_en) begin
            if (cnt == DWELL_LAST) begin
              cnt       <= '0;
              out_sel   <= next_sel;
              out_valid <= 1'b0;
              state     <= SWITCH;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        SWITCH: begin
          // A new load here retargets and keeps blanking for another cycle.
          if (load_req) begin
            out_sel <= sel;
          end else begin
            out       <= cur_data;
            out_valid <= 1'b1;
            switched  <= 1'b1;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
